// File: rtl/axi_receive_fifo.sv
// rtl/axi_receive_fifo.sv - beat-to-word deserialiser with optional address-to-ID translation and output FIFO
module axi_receive_fifo #(
  parameter int          BUS_WIDTH    = 32,
  parameter int          DATA_WIDTH   = 16,
  parameter int          DEPTH        = 4,
  parameter int          MSB_FIRST    = 0,
  parameter logic [31:0] ADDR_CEILING = 32'h3C,
  parameter logic [15:0] ID_CEILING   = 16'h0F,
  parameter int          STRIDE_LOG2  = 2,
  localparam int         NBEATS       = (BUS_WIDTH < DATA_WIDTH) ? DATA_WIDTH / BUS_WIDTH : 1,
  localparam int         CNT_W        = $clog2(NBEATS) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  is_addr,
  input  logic                  flush,
  input  logic [BUS_WIDTH-1:0]  in_packet,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_oor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CNT_W-1:0]      beat_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int AW    = (BUS_WIDTH > DATA_WIDTH) ? BUS_WIDTH : DATA_WIDTH;
  localparam int CW    = (AW > 32) ? AW : 32;
  localparam int EW    = DATA_WIDTH + 1;

  if (BUS_WIDTH < DATA_WIDTH && (DATA_WIDTH % BUS_WIDTH) != 0) begin : g_bad_width
    $error("axi_receive_fifo: DATA_WIDTH must be a multiple of BUS_WIDTH");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("axi_receive_fifo: DEPTH must be a power of two >= 2");
  end

  logic                  accept;
  logic                  last_beat;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  empty;
  logic [DATA_WIDTH-1:0] word;
  logic [AW-1:0]         addr_src;
  logic [CW-1:0]         addr_ext;
  logic                  in_range;
  logic [DATA_WIDTH-1:0] push_data;
  logic                  push_oor;

  // The final beat is merged combinationally so the word is pushed on the same edge.
  if (NBEATS > 1) begin : g_asm
    logic [DATA_WIDTH-1:0] asm_q;
    logic [DATA_WIDTH-1:0] asm_next;
    logic [CNT_W-1:0]      slot;

    always_comb begin
      slot     = (MSB_FIRST != 0) ? CNT_W'(NBEATS - 1) - beat_cnt : beat_cnt;
      asm_next = asm_q;
      asm_next[slot*BUS_WIDTH +: BUS_WIDTH] = in_packet;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        asm_q <= '0;
      end else if (flush || (accept && last_beat)) begin
        asm_q <= '0;
      end else if (accept) begin
        asm_q <= asm_next;
      end
    end

    assign last_beat = (beat_cnt == CNT_W'(NBEATS - 1));
    assign word      = asm_next;
    assign addr_src  = asm_next;
  end else begin : g_wide
    assign last_beat = 1'b1;
    assign word      = in_packet[DATA_WIDTH-1:0];
    assign addr_src  = in_packet;
  end

  assign addr_ext  = CW'(addr_src);
  assign in_range  = (addr_ext <= CW'(ADDR_CEILING));
  assign push_data = !is_addr ? word
                   : in_range ? DATA_WIDTH'(addr_ext >> STRIDE_LOG2)
                   : DATA_WIDTH'(ID_CEILING);
  assign push_oor  = is_addr && !in_range;

  logic [EW-1:0]    mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  assign full      = (count == (PTR_W + 1)'(DEPTH));
  assign empty     = (count == '0);
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign in_ready  = !full || pop;
  assign accept    = in_valid && in_ready;
  assign push      = accept && last_beat && !flush;

  assign {out_oor, out_data} = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {push_oor, push_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      beat_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (flush) begin
        beat_cnt <= '0;
      end else if (accept) begin
        beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi_receive_fifo.sv
// tb/tb_axi_receive_fifo.sv - scoreboard bench for axi_receive_fifo across four parameter sets
module tb_axi_receive_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // 8->16 pair (LSB-first and MSB-first) sharing one stimulus
  logic        flush_a, vld_a, rdy_a;
  logic [7:0]  pkt_a;
  logic        lsb_ir, lsb_ov, lsb_oor, msb_ir, msb_ov, msb_oor;
  logic [15:0] lsb_od, msb_od;
  logic [1:0]  lsb_bc, msb_bc;

  // 32->16 truncating / address mode
  logic        isa_w, flush_w, vld_w, rdy_w;
  logic [31:0] pkt_w;
  logic        w_ir, w_ov, w_oor;
  logic [15:0] w_od;
  logic [0:0]  w_bc;

  // 8->32 random traffic
  logic        vld_r, rdy_r, r_done;
  logic [7:0]  pkt_r;
  logic        r_ir, r_ov, r_oor;
  logic [31:0] r_od;
  logic [2:0]  r_bc;

  axi_receive_fifo #(.BUS_WIDTH(8), .DATA_WIDTH(16), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .is_addr(1'b0), .flush(flush_a), .in_packet(pkt_a),
    .in_valid(vld_a), .in_ready(lsb_ir), .out_data(lsb_od), .out_oor(lsb_oor),
    .out_valid(lsb_ov), .out_ready(rdy_a), .beat_cnt(lsb_bc));

  axi_receive_fifo #(.BUS_WIDTH(8), .DATA_WIDTH(16), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst_n(rst_n), .is_addr(1'b0), .flush(flush_a), .in_packet(pkt_a),
    .in_valid(vld_a), .in_ready(msb_ir), .out_data(msb_od), .out_oor(msb_oor),
    .out_valid(msb_ov), .out_ready(rdy_a), .beat_cnt(msb_bc));

  axi_receive_fifo u_wide (
    .clk(clk), .rst_n(rst_n), .is_addr(isa_w), .flush(flush_w), .in_packet(pkt_w),
    .in_valid(vld_w), .in_ready(w_ir), .out_data(w_od), .out_oor(w_oor),
    .out_valid(w_ov), .out_ready(rdy_w), .beat_cnt(w_bc));

  axi_receive_fifo #(.BUS_WIDTH(8), .DATA_WIDTH(32)) u_rand (
    .clk(clk), .rst_n(rst_n), .is_addr(1'b0), .flush(1'b0), .in_packet(pkt_r),
    .in_valid(vld_r), .in_ready(r_ir), .out_data(r_od), .out_oor(r_oor),
    .out_valid(r_ov), .out_ready(rdy_r), .beat_cnt(r_bc));

  int total = 0;
  int bad   = 0;
  logic [32:0] q_lsb[$], q_msb[$], q_w[$], q_r[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Pops happen at the next rising edge; inputs are stable from posedge+1 so the negedge sees them.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && lsb_ov && rdy_a) begin
      if (q_lsb.size() == 0) check("lsb_extra", 1, 0);
      else check("lsb_word", {lsb_oor, lsb_od}, q_lsb.pop_front());
    end
    if (rst_n === 1'b1 && msb_ov && rdy_a) begin
      if (q_msb.size() == 0) check("msb_extra", 1, 0);
      else check("msb_word", {msb_oor, msb_od}, q_msb.pop_front());
    end
    if (rst_n === 1'b1 && w_ov && rdy_w) begin
      if (q_w.size() == 0) check("wide_extra", 1, 0);
      else check("wide_word", {w_oor, w_od}, q_w.pop_front());
    end
    if (rst_n === 1'b1 && r_ov && rdy_r) begin
      if (q_r.size() == 0) check("rand_extra", 1, 0);
      else check("rand_word", {r_oor, r_od}, q_r.pop_front());
    end
  end

  task automatic beat_a(input logic [7:0] b);
    int n = 0;
    pkt_a = b;
    vld_a = 1'b1;
    @(negedge clk);
    while (!lsb_ir && n < 200) begin n++; @(negedge clk); end
    if (n >= 200) check("a_timeout", 1, 0);
    @(posedge clk); #1 vld_a = 1'b0;
  endtask

  task automatic word_a(input logic [7:0] b0, input logic [7:0] b1);
    q_lsb.push_back({17'b0, b1, b0});
    q_msb.push_back({17'b0, b0, b1});
    beat_a(b0);
    beat_a(b1);
  endtask

  task automatic beat_w(input logic [31:0] p, input logic isa, input logic [32:0] exp);
    int n = 0;
    q_w.push_back(exp);
    pkt_w = p;
    isa_w = isa;
    vld_w = 1'b1;
    @(negedge clk);
    while (!w_ir && n < 200) begin n++; @(negedge clk); end
    if (n >= 200) check("w_timeout", 1, 0);
    @(posedge clk); #1 vld_w = 1'b0;
  endtask

  task automatic beat_r(input logic [7:0] b);
    int n = 0;
    pkt_r = b;
    vld_r = 1'b1;
    @(negedge clk);
    while (!r_ir && n < 200) begin n++; @(negedge clk); end
    if (n >= 200) check("r_timeout", 1, 0);
    @(posedge clk); #1 vld_r = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q_lsb.size() + q_msb.size() + q_w.size() + q_r.size()) != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    check("drain", q_lsb.size() + q_msb.size() + q_w.size() + q_r.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] word;
    rst_n = 1'b0;
    flush_a = 0; vld_a = 0; rdy_a = 1; pkt_a = '0;
    isa_w = 0; flush_w = 0; vld_w = 0; rdy_w = 1; pkt_w = '0;
    vld_r = 0; rdy_r = 1; pkt_r = '0; r_done = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", lsb_ov, 0);
    check("rst_data", {lsb_oor, lsb_od}, 0);
    check("rst_ready", lsb_ir, 1);
    check("rst_bcnt", lsb_bc, 0);
    check("rst_w_valid", w_ov, 0);
    check("rst_w_ready", w_ir, 1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // basic deserialisation and one-cycle latency
    q_lsb.push_back(33'h1234);
    q_msb.push_back(33'h3412);
    beat_a(8'h34);
    check("lat_pre", lsb_ov, 0);
    beat_a(8'h12);
    check("lat_lsb", lsb_ov, 1);
    check("lat_msb", msb_ov, 1);
    drain();

    // flush of a partial word, then flush coincident with a beat
    beat_a(8'hAA);
    check("fl_bc1", lsb_bc, 1);
    check("fl_msb_bc1", msb_bc, 1);
    flush_a = 1'b1;
    @(posedge clk); #1 flush_a = 1'b0;
    check("fl_bc0", lsb_bc, 0);
    q_lsb.push_back(33'h1234);
    q_msb.push_back(33'h3412);
    beat_a(8'h34);
    check("fl_bc_a", lsb_bc, 1);
    beat_a(8'h12);
    check("fl_bc_b", lsb_bc, 0);
    beat_a(8'h77);
    flush_a = 1'b1; pkt_a = 8'h55; vld_a = 1'b1;
    @(posedge clk); #1 flush_a = 1'b0; vld_a = 1'b0;
    check("fl_coinc_bc", lsb_bc, 0);
    word_a(8'h34, 8'h12);
    drain();

    // address translation and wide-bus truncation
    beat_w(32'h0000000C, 1'b1, {1'b0, 16'h0003});
    beat_w(32'h0000003C, 1'b1, {1'b0, 16'h000F});
    beat_w(32'h00000040, 1'b1, {1'b1, 16'h000F});
    beat_w(32'h1000000C, 1'b1, {1'b1, 16'h000F});
    beat_w(32'hDEADBEEF, 1'b0, {1'b0, 16'hBEEF});
    drain();

    // full FIFO, held beat, then simultaneous push and pop
    rdy_w = 1'b0;
    for (int i = 1; i <= 4; i++) beat_w(32'(i), 1'b0, 33'(i));
    @(negedge clk);
    check("full_ready", w_ir, 0);
    q_w.push_back(33'h5);
    pkt_w = 32'h5; isa_w = 1'b0; vld_w = 1'b1;
    repeat (2) @(negedge clk);
    check("full_held", w_ir, 0);
    check("full_head", {w_oor, w_od}, 1);
    @(posedge clk); #1 rdy_w = 1'b1;
    @(negedge clk);
    check("pushpop_ready", w_ir, 1);
    @(posedge clk); #1 vld_w = 1'b0;
    drain();

    // async reset with a partial word and two queued words
    rdy_a = 1'b0;
    word_a(8'h11, 8'h22);
    word_a(8'h33, 8'h44);
    beat_a(8'h99);
    check("pre_rst_bc", lsb_bc, 1);
    check("pre_rst_valid", lsb_ov, 1);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    check("arst_valid", lsb_ov, 0);
    check("arst_msb_valid", msb_ov, 0);
    check("arst_ready", lsb_ir, 1);
    check("arst_bc", lsb_bc, 0);
    check("arst_data", lsb_od, 0);
    q_lsb.delete();
    q_msb.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1 rdy_a = 1'b1;
    word_a(8'h01, 8'h02);
    drain();

    // random gaps and backpressure, 1000 words
    fork
      begin
        for (int w = 0; w < 1000; w++) begin
          word = $urandom;
          q_r.push_back({1'b0, word});
          for (int b = 0; b < 4; b++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            beat_r(word[b*8 +: 8]);
          end
        end
        r_done = 1'b1;
      end
      begin
        while (!r_done) begin
          @(posedge clk); #1 rdy_r = 1'($urandom_range(0, 1));
        end
      end
    join
    rdy_r = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
